alu_share_arbiter: RTL and testbench

//   Shares one combinational ALU (op1/op2/alu_sel -> res/zero/negative) between two requesters:

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_share_arbiter_rr_arb2.sv | 30 +++
 rtl/alu_share_arbiter.sv | 109 ++++++++++
 tb/tb_alu_share_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU select codes and response-slot state.
package alu_pkg;

  localparam int unsigned ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_LUI = 4'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL = 4'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL = 4'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA = 4'd5;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR = 4'd6;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'd7;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'd8;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT = 4'd9;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin against last_grant, or port 0 always first when FIXED_PRIO.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       last_grant_d
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (FIXED_PRIO || last_grant) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Priority only rotates when the grant actually turns into a transfer.
  always_comb begin
    last_grant_d = last_grant;
    if (advance && (gnt != 2'b00)) begin
      last_grant_d = gnt[1];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters and registers its result
// into a one-entry response slot with valid/ready handshakes on every side.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_op1,
  input  logic [DATA_W-1:0] r0_op2,
  input  logic [SEL_W-1:0]  r0_sel,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_op1,
  input  logic [DATA_W-1:0] r1_op2,
  input  logic [SEL_W-1:0]  r1_sel,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero,
  input  logic              alu_neg,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_zero,
  output logic              rsp_neg
);

  slot_state_e       state_q;
  logic              last_grant_q;
  logic              last_grant_d;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_res_q;
  logic              rsp_zero_q;
  logic              rsp_neg_q;
  logic [1:0]        gnt;
  logic              can_accept_c;
  logic              xfer_c;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_arb (
    .req          ({r1_valid, r0_valid}),
    .last_grant   (last_grant_q),
    .advance      (xfer_c),
    .gnt          (gnt),
    .last_grant_d (last_grant_d)
  );

  assign can_accept_c = (state_q == EMPTY) || rsp_ready;
  assign r0_ready     = gnt[0] && can_accept_c;
  assign r1_ready     = gnt[1] && can_accept_c;
  assign xfer_c       = r0_ready || r1_ready;

  // The ALU follows the grant even when the slot cannot take the result yet.
  always_comb begin
    alu_op1 = '0;
    alu_op2 = '0;
    alu_sel = '0;
    if (gnt[0]) begin
      alu_op1 = r0_op1;
      alu_op2 = r0_op2;
      alu_sel = r0_sel;
    end else if (gnt[1]) begin
      alu_op1 = r1_op1;
      alu_op2 = r1_op2;
      alu_sel = r1_sel;
    end
  end

  // Slot FSM and response payload; a new transfer overwrites the slot in the same edge it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_res_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_neg_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      case (state_q)
        EMPTY:   if (xfer_c) state_q <= FULL;
        FULL:    if (!xfer_c && rsp_ready) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (xfer_c) begin
        rsp_id_q   <= gnt[1];
        rsp_res_q  <= alu_res;
        rsp_zero_q <= alu_zero;
        rsp_neg_q  <= alu_neg;
      end
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_neg   = rsp_neg_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share stimulus and are
// checked against a transaction-level model of the arbitration and response slot.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        neg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r1_valid, rsp_ready;
  logic [31:0] r0_op1, r0_op2, r1_op1, r1_op2;
  logic [3:0]  r0_sel, r1_sel;

  logic        rdy0_a   [2];
  logic        rdy1_a   [2];
  logic [31:0] aop1_a   [2];
  logic [31:0] aop2_a   [2];
  logic [3:0]  asel_a   [2];
  logic [31:0] ares_a   [2];
  logic        azero_a  [2];
  logic        aneg_a   [2];
  logic        rspv_a   [2];
  logic        rspid_a  [2];
  logic [31:0] rspres_a [2];
  logic        rspz_a   [2];
  logic        rspn_a   [2];

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sbq [2][$];
  int   last_m [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] s);
    case (s)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_LUI: return b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return 32'($signed(a) >>> b[4:0]);
      ALU_XOR: return a ^ b;
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
      default: return 32'd0;
    endcase
  endfunction

  // External ALU beside each instance.
  for (genvar g = 0; g < 2; g++) begin : g_alu
    assign ares_a[g]  = alu_f(aop1_a[g], aop2_a[g], asel_a[g]);
    assign azero_a[g] = (ares_a[g] == 32'd0);
    assign aneg_a[g]  = ares_a[g][31];
  end

  alu_share_arbiter #(.DATA_W(32), .SEL_W(4), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(rdy0_a[0]), .r0_op1(r0_op1), .r0_op2(r0_op2), .r0_sel(r0_sel),
    .r1_valid(r1_valid), .r1_ready(rdy1_a[0]), .r1_op1(r1_op1), .r1_op2(r1_op2), .r1_sel(r1_sel),
    .alu_op1(aop1_a[0]), .alu_op2(aop2_a[0]), .alu_sel(asel_a[0]),
    .alu_res(ares_a[0]), .alu_zero(azero_a[0]), .alu_neg(aneg_a[0]),
    .rsp_valid(rspv_a[0]), .rsp_ready(rsp_ready), .rsp_id(rspid_a[0]),
    .rsp_res(rspres_a[0]), .rsp_zero(rspz_a[0]), .rsp_neg(rspn_a[0])
  );

  alu_share_arbiter #(.DATA_W(32), .SEL_W(4), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(rdy0_a[1]), .r0_op1(r0_op1), .r0_op2(r0_op2), .r0_sel(r0_sel),
    .r1_valid(r1_valid), .r1_ready(rdy1_a[1]), .r1_op1(r1_op1), .r1_op2(r1_op2), .r1_sel(r1_sel),
    .alu_op1(aop1_a[1]), .alu_op2(aop2_a[1]), .alu_sel(asel_a[1]),
    .alu_res(ares_a[1]), .alu_zero(azero_a[1]), .alu_neg(aneg_a[1]),
    .rsp_valid(rspv_a[1]), .rsp_ready(rsp_ready), .rsp_id(rspid_a[1]),
    .rsp_res(rspres_a[1]), .rsp_zero(rspz_a[1]), .rsp_neg(rspn_a[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Winner of a contest: -1 none, else port number.
  function automatic int grant_m(input logic v0, input logic v1, input int last, input bit fixed);
    if (v0 && v1) return (fixed || last == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Monitor: compare the slot against the expected queue, then predict this cycle's grant.
  always @(negedge clk) begin
    bit          full;
    bit          can;
    int          g;
    exp_t        e;
    logic [31:0] x1, x2;
    logic [3:0]  xs;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        sbq[i].delete();
        last_m[i] = 1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        full = (sbq[i].size() != 0);
        chk($sformatf("rsp_valid[%0d]", i), 32'(rspv_a[i]), 32'(full));
        if (full && rspv_a[i]) begin
          e = sbq[i][0];
          chk($sformatf("rsp_id[%0d]", i),   32'(rspid_a[i]), 32'(e.id));
          chk($sformatf("rsp_res[%0d]", i),  rspres_a[i],     e.res);
          chk($sformatf("rsp_zero[%0d]", i), 32'(rspz_a[i]),  32'(e.zero));
          chk($sformatf("rsp_neg[%0d]", i),  32'(rspn_a[i]),  32'(e.neg));
        end
        if (full && rsp_ready) void'(sbq[i].pop_front());
        g   = grant_m(r0_valid, r1_valid, last_m[i], i == 1);
        can = !full || rsp_ready;
        chk($sformatf("r0_ready[%0d]", i), 32'(rdy0_a[i]), 32'(g == 0 && can));
        chk($sformatf("r1_ready[%0d]", i), 32'(rdy1_a[i]), 32'(g == 1 && can));
        x1 = (g == 0) ? r0_op1 : (g == 1) ? r1_op1 : 32'd0;
        x2 = (g == 0) ? r0_op2 : (g == 1) ? r1_op2 : 32'd0;
        xs = (g == 0) ? r0_sel : (g == 1) ? r1_sel : 4'd0;
        chk($sformatf("alu_op1[%0d]", i), aop1_a[i], x1);
        chk($sformatf("alu_op2[%0d]", i), aop2_a[i], x2);
        chk($sformatf("alu_sel[%0d]", i), 32'(asel_a[i]), 32'(xs));
        if (g >= 0 && can) begin
          e.id   = (g == 1);
          e.res  = alu_f(x1, x2, xs);
          e.zero = (e.res == 32'd0);
          e.neg  = e.res[31];
          sbq[i].push_back(e);
          last_m[i] = g;
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_r0(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    r0_valid = v; r0_sel = s; r0_op1 = a; r0_op2 = b;
  endtask

  task automatic set_r1(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    r1_valid = v; r1_sel = s; r1_op1 = a; r1_op2 = b;
  endtask

  initial begin
    bit h0, h1;
    rst = 1'b1; rsp_ready = 1'b0;
    set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    set_r1(1'b0, 4'd0, 32'd0, 32'd0);
    cyc(2);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset rsp_valid", 32'(rspv_a[i]), 32'd0);
      chk("reset rsp_res",   rspres_a[i],    32'd0);
      chk("reset rsp_id",    32'(rspid_a[i]), 32'd0);
    end
    cyc(); rst = 1'b0;

    // Single op: ADD 6,5 -> 11 one cycle later.
    rsp_ready = 1'b1;
    set_r0(1'b1, ALU_ADD, 32'd6, 32'd5);
    @(negedge clk); chk("t1 r0_ready", 32'(rdy0_a[0]), 32'd1);
    cyc(); set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("t1 rsp_valid", 32'(rspv_a[0]), 32'd1);
    chk("t1 rsp_res",   rspres_a[0],    32'd11);
    cyc(2);

    // Contention with both ports valid.
    set_r0(1'b1, ALU_SUB, 32'd3, 32'd3);
    set_r1(1'b1, ALU_XOR, 32'hF0, 32'h0F);
    cyc(4);
    set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    set_r1(1'b0, 4'd0, 32'd0, 32'd0);
    cyc(2);

    // Backpressure: slot holds SLT -1,1 = 1 while r0 waits.
    rsp_ready = 1'b0;
    set_r1(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    cyc();
    set_r1(1'b0, 4'd0, 32'd0, 32'd0);
    set_r0(1'b1, ALU_OR, 32'h1234, 32'h0F00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3 hold r0_ready", 32'(rdy0_a[0]), 32'd0);
      chk("t3 hold rsp_res",  rspres_a[0],    32'd1);
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk); chk("t3 release r0_ready", 32'(rdy0_a[0]), 32'd1);
    cyc(); set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    cyc(2);

    // Both valid: fixed-priority instance never serves port 1.
    set_r0(1'b1, ALU_AND, 32'hFF00, 32'h0FF0);
    set_r1(1'b1, ALU_SRA, 32'h8000_0000, 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("t4 fp r1_ready", 32'(rdy1_a[1]), 32'd0);
      cyc();
    end

    // Reset while slot is full and both ports valid.
    rsp_ready = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("t5 rsp_valid", 32'(rspv_a[0]), 32'd0);
    chk("t5 rsp_res",   rspres_a[0],    32'd0);
    chk("t5 r0 wins",   32'(rdy0_a[0]), 32'd1);
    rsp_ready = 1'b1;
    cyc();
    set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    set_r1(1'b0, 4'd0, 32'd0, 32'd0);

    // Idle: ALU driven to zero, slot drains.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6 alu_op1", aop1_a[0], 32'd0);
      cyc();
    end
    @(negedge clk); chk("t6 rsp_valid", 32'(rspv_a[0]), 32'd0);

    // Random traffic; requesters hold their fields while stalled.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      h0 = r0_valid && !rdy0_a[0];
      h1 = r1_valid && !rdy1_a[0];
      cyc();
      if (!h0) set_r0(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom),
                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom));
      if (!h1) set_r1(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom),
                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    set_r0(1'b0, 4'd0, 32'd0, 32'd0);
    set_r1(1'b0, 4'd0, 32'd0, 32'd0);
    rsp_ready = 1'b1;
    cyc(5);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
